// File: rtl/cpu_word_pkg.sv
// Shared types and widths for the 8-bit CPU word-fetch logic.
package cpu_word_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2,
    DONE   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/word_fetch_seq_join.sv
// Join_16B: concatenates a high and a low byte into one 16-bit word.
module Join_16B
  import cpu_word_pkg::*;
(
  input  logic [BYTE_W-1:0] low,
  input  logic [BYTE_W-1:0] high,
  output logic [WORD_W-1:0] word
);

  assign word = {high, low};

endmodule

// File: rtl/word_fetch_seq.sv
// word_fetch_seq: fetches two consecutive bytes over a req/ack memory port
// and presents them as one 16-bit word under a valid/ready handshake.
// Optional macro WORD_FETCH_HIGH_FIRST_EN selects big-endian byte order
// (byte at base goes to the high half); undefined gives little-endian.
module word_fetch_seq
  import cpu_word_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word,
  output logic              err
);

  // The counter only has to reach TIMEOUT-1 (the last cycle of a phase).
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
  localparam bit TO_EN = (TIMEOUT != 0);

  fetch_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              busy_d, mem_req_d, word_valid_d, err_d;
  logic              fire, to_hit, latch0, latch1;
  logic [BYTE_W-1:0] byte0_q, low_q, high_q;

  assign fire   = mem_req && mem_ack;
  assign to_hit = TO_EN && (cnt_q == CNT_LAST);

  // Next-state, timeout counting and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    latch0   = 1'b0;
    latch1   = 1'b0;
    base_d   = base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH0;
          cnt_d   = '0;
          base_d  = base_addr;
        end
      end
      FETCH0: begin
        if (fire) begin
          state_d = FETCH1;
          cnt_d   = '0;
          latch0  = 1'b1;
        end else if (to_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH1: begin
        if (fire) begin
          state_d = DONE;
          latch1  = 1'b1;
        end else if (to_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (word_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE);
    mem_req_d    = (state_d == FETCH0) || (state_d == FETCH1);
    word_valid_d = (state_d == DONE);
    mem_addr_d   = mem_addr;
    if (state_d == FETCH0) mem_addr_d = base_d;
    else if (state_d == FETCH1) mem_addr_d = base_d + ADDR_W'(1);
  end

  // State, counter, captured base and all control outputs as flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      busy       <= busy_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      word_valid <= word_valid_d;
      err        <= err_d;
    end
  end

  // First byte is staged so the visible word only changes when a fetch completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte0_q <= '0;
      low_q   <= '0;
      high_q  <= '0;
    end else begin
      if (latch0) byte0_q <= mem_rdata;
      if (latch1) begin
`ifdef WORD_FETCH_HIGH_FIRST_EN
        high_q <= byte0_q;
        low_q  <= mem_rdata;
`else
        low_q  <= byte0_q;
        high_q <= mem_rdata;
`endif
      end
    end
  end

  Join_16B u_join (
    .low  (low_q),
    .high (high_q),
    .word (word)
  );

endmodule

// File: doc/word_fetch_seq.md
# word_fetch_seq

Sequencer that assembles a 16-bit word from two consecutive 8-bit memory reads for the 8-bit CPU (jump targets, 16-bit immediates, pointer loads). On `start` it issues two byte reads over a req/ack handshake, at `base_addr` and `base_addr+1`, and latches the low and high bytes. It then presents the joined word under a valid/ready handshake. A per-read timeout aborts a stalled read and flags an error.

## Interface
- `ADDR_W`, default 8: memory address width.
- `TIMEOUT`, default 15: maximum cycles to wait for `mem_ack` per read; 0 disables the timeout.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a word fetch; sampled only in IDLE.
- `base_addr`  in  ADDR_W  address of the first byte; captured when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  ADDR_W  byte read address.
- `mem_ack`  in  1  read completes at any edge where `mem_req && mem_ack`.
- `mem_rdata`  in  8  read data, valid with `mem_ack`.
- `word_valid`  out  1  `word` holds a completed fetch.
- `word_ready`  in  1  consumer accepts `word`.
- `word`  out  16  assembled word, {high, low}.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States:
  - IDLE → FETCH0 on `start`; `base_addr` is captured.
  - FETCH0 → FETCH1 on ack.
  - FETCH1 → DONE on ack.
  - DONE → IDLE on `word_ready`.
  - FETCH0 or FETCH1 → IDLE on timeout, with `err` pulsed.
- FETCH0 reads `base`. FETCH1 reads `base+1`, computed mod 2^ADDR_W; `base` = all-ones wraps to 0.
- Default byte order (little-endian): the FETCH0 byte goes to `low`, the FETCH1 byte goes to `high`.
- `start` is ignored outside IDLE. `base_addr` changes after capture have no effect.
- `mem_ack` is ignored while `mem_req`=0.
- Timeout counter:
  - Clears on entry to each FETCH state and counts cycles without ack.
  - If no ack arrives in the TIMEOUT-th cycle of a phase, the state returns to IDLE at the end of that cycle.
  - An ack arriving in that same cycle takes priority: the read completes, no error.
- On timeout, the byte registers are not updated, `word_valid` stays 0 and `err`=1 for exactly the next cycle.
- `word` is held stable while `word_valid`=1. `word` retains its last value after leaving DONE.
- Reset mid-fetch aborts immediately. No `err` is generated; the state returns to IDLE.

## Timing
- Reset values: state IDLE; `busy`, `mem_req`, `word_valid`, `err` = 0; `mem_addr` = 0; `word` = 0x0000.
- All outputs are registered.
- Minimum latency (both acks zero-wait), with `start` high in cycle 0:
  - Cycle 1: `mem_req`=1, `mem_addr`=base.
  - Cycle 2: `mem_req`=1, `mem_addr`=base+1.
  - Cycle 3: `word_valid`=1.
- `mem_req` stays high across the FETCH0→FETCH1 boundary; only the address changes.
- `mem_addr` is stable while `mem_req`=1 and no ack has occurred.
- `busy` rises in cycle 1 and falls in the cycle after the `word_ready` handshake or timeout.
- A `start` that coincides with the DONE handshake is ignored. The next `start` is accepted in IDLE, so the minimum word-to-word spacing is 4 cycles.

## Configuration
- Macro `WORD_FETCH_HIGH_FIRST_EN`.
- Defined: big-endian order; the FETCH0 byte (at `base`) goes to `high` and the FETCH1 byte (at `base+1`) goes to `low`.
- Undefined: little-endian order, as described in Operation.
- Addresses, timing and handshakes are identical in both builds.

## Structure
- Shared package `cpu_word_pkg`: state enum (IDLE, FETCH0, FETCH1, DONE) and constants BYTE_W=8, WORD_W=16.
- One sub-module: the existing byte joiner `Join_16B` is instantiated to form `word` from the `low` and `high` byte registers.
- The FSM, timeout counter and byte registers stay in `word_fetch_seq`.

## Test plan
- Zero-wait fetch, little-endian: `base_addr`=0x40, mem[0x40]=0x34, mem[0x41]=0x12, acks immediate → `word`=0x1234 with `word_valid` in cycle 3.
- Wait states and backpressure: 2-cycle ack delay per read, `word_ready` held low 5 cycles → `mem_addr` stable through the waits; `word` is held until the handshake and `busy` drops the following cycle.
- Address wrap: `base_addr`=0xFF (ADDR_W=8) → second read at 0x00. With `WORD_FETCH_HIGH_FIRST_EN` and mem[0xFF]=0xAB, mem[0x00]=0xCD → `word`=0xABCD.
- Timeout: TIMEOUT=15, ack withheld in FETCH1 → return to IDLE after 15 cycles, `err` pulses once, `word_valid` never asserts. An ack arriving in cycle 15 instead completes normally.
- Reset mid-FETCH0, plus `start` pulsed while busy → all outputs at reset values immediately, no `err`; the extra `start` causes no second fetch.
